// File: rtl/nios2_system_key_debounce.sv
// Push-button conditioner for the Nios II key PIO.
// Each channel synchronises its raw active-low key into clk and accepts a new level only after
// it has been stable for DEBOUNCE_CYCLES consecutive cycles. The downstream falling-edge capture
// therefore sees exactly one edge per physical press.
module nios2_system_key_debounce #(
  parameter int unsigned WIDTH           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19,
  parameter logic        IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  typedef enum logic {StStable, StPending} state_e;

  // Terminal count: the filter edge that sees the DEBOUNCE_CYCLES-th consecutive mismatch.
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic             s1;
    logic             s2;
    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             press;
    logic             rel;

    // Two-flop synchroniser; only s2 is allowed to reach the filter.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1 <= IDLE_LEVEL;
        s2 <= IDLE_LEVEL;
      end else begin
        s1 <= key_raw[i];
        s2 <= s1;
      end
    end

    // Stability filter: count consecutive mismatches, accept the level at the terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state <= StStable;
        cnt   <= '0;
        level <= IDLE_LEVEL;
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        // Strobes last one cycle unless re-asserted by a toggle below.
        press <= 1'b0;
        rel   <= 1'b0;
        case (state)
          StStable: begin
            if (s2 != level) begin
              if (DEBOUNCE_CYCLES == 1) begin
                // A single stable cycle is enough: accept straight away.
                level <= s2;
                press <= (s2 != IDLE_LEVEL);
                rel   <= (s2 == IDLE_LEVEL);
              end else begin
                state <= StPending;
                cnt   <= CNT_W'(1);
              end
            end
          end
          StPending: begin
            if (s2 == level) begin
              // Bounced back before the window closed: forget the attempt.
              state <= StStable;
              cnt   <= '0;
            end else if (cnt == CntMax) begin
              level <= s2;
              press <= (s2 != IDLE_LEVEL);
              rel   <= (s2 == IDLE_LEVEL);
              state <= StStable;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= StStable;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign key_out[i]       = level;
    assign press_pulse[i]   = press;
    assign release_pulse[i] = rel;
  end

endmodule

// File: tb/tb_nios2_system_key_debounce.sv
// Directed bench for nios2_system_key_debounce with DEBOUNCE_CYCLES=4, CNT_W=2.
// A small model of the downstream PIO falling-edge capture is included.
module tb_nios2_system_key_debounce;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [2:0] key_raw = 3'b000;
  logic [2:0] key_out;
  logic [2:0] press_pulse;
  logic [2:0] release_pulse;

  int checks = 0;
  int errors = 0;

  // Downstream PIO model: history flops reset to 0, sticky falling-edge capture.
  logic [2:0] pio_prev;
  logic [2:0] edge_cap;
  logic       cap_clr = 1'b0;

  nios2_system_key_debounce #(
    .WIDTH          (3),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (2),
    .IDLE_LEVEL     (1'b1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_raw      (key_raw),
    .key_out      (key_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  // PIO falling-edge capture fed by key_out.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_prev <= 3'b000;
      edge_cap <= 3'b000;
    end else begin
      pio_prev <= key_out;
      if (cap_clr) edge_cap <= 3'b000;
      else         edge_cap <= edge_cap | (pio_prev & ~key_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Run n cycles with inputs held; the output toggles and pulses after cycle 'at'.
  task automatic run_expect(input string tag, input int n, input int at,
                            input logic [2:0] ko_pre, input logic [2:0] ko_post,
                            input logic [2:0] pr_exp, input logic [2:0] rl_exp);
    for (int t = 1; t <= n; t++) begin
      tick();
      if (t < at) begin
        check($sformatf("%s_ko_t%0d", tag, t), key_out, ko_pre);
        check($sformatf("%s_press_t%0d", tag, t), press_pulse, 3'b000);
        check($sformatf("%s_rel_t%0d", tag, t), release_pulse, 3'b000);
      end else if (t == at) begin
        check($sformatf("%s_ko_t%0d", tag, t), key_out, ko_post);
        check($sformatf("%s_press_t%0d", tag, t), press_pulse, pr_exp);
        check($sformatf("%s_rel_t%0d", tag, t), release_pulse, rl_exp);
      end else begin
        check($sformatf("%s_ko_t%0d", tag, t), key_out, ko_post);
        check($sformatf("%s_press_t%0d", tag, t), press_pulse, 3'b000);
        check($sformatf("%s_rel_t%0d", tag, t), release_pulse, 3'b000);
      end
    end
  endtask

  logic [15:0] bpat;

  initial begin
    // Reset with keys held low: outputs must still read idle.
    #2 reset_n = 1'b0;
    tick();
    tick();
    check("rst_ko", key_out, 3'b111);
    check("rst_press", press_pulse, 3'b000);
    check("rst_rel", release_pulse, 3'b000);

    key_raw = 3'b111;
    #2 reset_n = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      check("idle_ko", key_out, 3'b111);
      check("idle_press", press_pulse, 3'b000);
      check("idle_rel", release_pulse, 3'b000);
    end
    // Rising edge out of reset must not be captured as an interrupt.
    check("idle_edge_cap", edge_cap, 3'b000);

    // Clean press and release on channel 0.
    key_raw = 3'b110;
    run_expect("press0", 7, 6, 3'b111, 3'b110, 3'b001, 3'b000);
    key_raw = 3'b111;
    run_expect("rel0", 7, 6, 3'b110, 3'b111, 3'b000, 3'b001);

    // Bouncing press on channel 1: raw sampled per edge 0,0,1,1,1,0,1,1, then 0.
    bpat = 16'h00DC;
    for (int t = 1; t <= 16; t++) begin
      key_raw[1] = bpat[t-1];
      tick();
      if (t < 14) begin
        check("bounce_ko", key_out, 3'b111);
        check("bounce_press", press_pulse, 3'b000);
      end else if (t == 14) begin
        check("bounce_ko_acc", key_out, 3'b101);
        check("bounce_press_acc", press_pulse, 3'b010);
      end else begin
        check("bounce_ko_hold", key_out, 3'b101);
        check("bounce_press_after", press_pulse, 3'b000);
      end
      check("bounce_rel", release_pulse, 3'b000);
    end
    key_raw = 3'b111;
    run_expect("rel1", 7, 6, 3'b101, 3'b111, 3'b000, 3'b010);

    // Three-cycle glitch on channel 2 is filtered out.
    for (int t = 1; t <= 10; t++) begin
      key_raw[2] = (t <= 3) ? 1'b0 : 1'b1;
      tick();
      check("glitch_ko", key_out, 3'b111);
      check("glitch_press", press_pulse, 3'b000);
      check("glitch_rel", release_pulse, 3'b000);
    end

    // Reset while channel 0 is pending at count 2; the count must be discarded.
    key_raw = 3'b110;
    for (int t = 1; t <= 4; t++) begin
      tick();
    end
    reset_n = 1'b0;
    #1;
    check("midrst_ko", key_out, 3'b111);
    check("midrst_press", press_pulse, 3'b000);
    tick();
    #2 reset_n = 1'b1;
    run_expect("midrst_press0", 7, 6, 3'b111, 3'b110, 3'b001, 3'b000);
    key_raw = 3'b111;
    run_expect("midrst_rel0", 7, 6, 3'b110, 3'b111, 3'b000, 3'b001);

    // All three keys drop together.
    cap_clr = 1'b1;
    tick();
    cap_clr = 1'b0;
    check("par_cap_clr", edge_cap, 3'b000);
    key_raw = 3'b000;
    run_expect("par", 7, 6, 3'b111, 3'b000, 3'b111, 3'b000);
    check("par_edge_cap", edge_cap, 3'b111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
